// File: rtl/addsub_acc_unit.sv
// addsub_acc_unit: single-adder add/subtract unit with an accumulator,
// a one-deep registered result stage and valid/ready handshakes on both sides.
// Optional signed saturation on overflow (SAT=1); wrap-around otherwise.
module addsub_acc_unit #(
  parameter int WIDTH = 8,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic [WIDTH-1:0] acc
);

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             accept;
  logic             sub;
  logic             use_acc;
  logic [WIDTH-1:0] x_op;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             ovf_w;
  logic [WIDTH-1:0] res_w;

  // Reset forces ready high so upstream never sees a stall while the pipe is being flushed.
  assign in_ready = rst || !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Shared adder: subtraction is X + ~B + 1; a same-cycle clear makes the accumulator operand zero.
  always_comb begin
    sub     = mode[0];
    use_acc = mode[1];
    x_op    = A;
    if (use_acc) begin
      x_op = acc_clr ? '0 : acc_q;
    end
    b_eff = B ^ {WIDTH{sub}};
    sum   = {1'b0, x_op} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    ovf_w = (x_op[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != x_op[WIDTH-1]);
    res_w = sum[WIDTH-1:0];
    if ((SAT != 0) && ovf_w) begin
      res_w = x_op[WIDTH-1] ? SMIN : SMAX;
    end
  end

  // Next-state for the result stage and accumulator; everything holds unless accepted or cleared.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    acc_d       = acc_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = res_w;
      carry_d     = sum[WIDTH];
      ovf_d       = ovf_w;
      zero_d      = (res_w == '0);
      neg_d       = res_w[WIDTH-1];
      if (use_acc) begin
        acc_d = res_w;
      end else if (acc_clr) begin
        acc_d = '0;
      end
    end else begin
      if (out_ready) begin
        out_valid_d = 1'b0;
      end
      if (acc_clr) begin
        acc_d = '0;
      end
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_addsub_acc_unit.sv
// Bench for addsub_acc_unit: a wrap (SAT=0) and a saturating (SAT=1) instance
// share one stimulus stream; both are compared every cycle against an
// arithmetic reference model, plus directed vectors and sequences.
module tb_addsub_acc_unit;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, acc_clr, out_ready;
  logic [1:0]   mode;
  logic [W-1:0] a, b;

  logic         d_rdy[2], d_ov[2], d_c[2], d_o[2], d_z[2], d_n[2];
  logic [W-1:0] d_res[2], d_acc[2];

  addsub_acc_unit #(.WIDTH(W), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_rdy[0]), .mode(mode),
    .A(a), .B(b), .acc_clr(acc_clr), .out_valid(d_ov[0]), .out_ready(out_ready),
    .result(d_res[0]), .carry(d_c[0]), .ovf(d_o[0]), .zero(d_z[0]), .neg(d_n[0]),
    .acc(d_acc[0]));

  addsub_acc_unit #(.WIDTH(W), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_rdy[1]), .mode(mode),
    .A(a), .B(b), .acc_clr(acc_clr), .out_valid(d_ov[1]), .out_ready(out_ready),
    .result(d_res[1]), .carry(d_c[1]), .ovf(d_o[1]), .zero(d_z[1]), .neg(d_n[1]),
    .acc(d_acc[1]));

  int checks = 0;
  int failures = 0;

  // reference model state, index = SAT value
  logic         m_ov[2], m_c[2], m_o[2], m_z[2], m_n[2];
  logic [W-1:0] m_res[2], m_acc[2];

  // in-order scoreboard on the wrap instance
  bit     sb_on = 1'b0;
  logic [W-1:0] sb_q[$];
  int     sb_pushed = 0;
  int     sb_popped = 0;

  typedef struct {
    bit         sat;
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       o;
    logic       z;
    logic       n;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Plain signed/unsigned arithmetic, no bit-level adder.
  function automatic void calc(input int x, input int bv, input bit sub, input bit sat,
                               output logic [7:0] res, output logic c, output logic o);
    int sx, sbv, r;
    sx  = (x  >= 128) ? x  - 256 : x;
    sbv = (bv >= 128) ? bv - 256 : bv;
    if (sub) begin
      r = sx - sbv;
      c = (x >= bv);
    end else begin
      r = sx + sbv;
      c = ((x + bv) >= 256);
    end
    o = (r > 127) || (r < -128);
    if (o && sat) r = (r > 127) ? 127 : -128;
    res = 8'(r & 255);
  endfunction

  task automatic step();
    logic       rdy, acc_ok, c, o;
    logic [7:0] res;
    int         x;
    #1;
    for (int i = 0; i < 2; i++) begin
      rdy = rst || !m_ov[i] || out_ready;
      chk($sformatf("in_ready[%0d]", i), d_rdy[i], rdy);
    end
    if (sb_on && d_ov[0] && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual=result_0x%0h required=no_result", d_res[0]);
      end else begin
        chk("sb_result", d_res[0], sb_q.pop_front());
      end
      sb_popped++;
    end
    for (int i = 0; i < 2; i++) begin
      rdy    = rst || !m_ov[i] || out_ready;
      acc_ok = in_valid && rdy;
      if (rst) begin
        m_ov[i] = 0; m_res[i] = 0; m_c[i] = 0; m_o[i] = 0; m_z[i] = 0; m_n[i] = 0; m_acc[i] = 0;
      end else if (acc_ok) begin
        x = mode[1] ? (acc_clr ? 0 : int'(m_acc[i])) : int'(a);
        calc(x, int'(b), mode[0], (i == 1), res, c, o);
        m_res[i] = res; m_c[i] = c; m_o[i] = o; m_z[i] = (res == 0); m_n[i] = res[7];
        m_ov[i] = 1;
        if (mode[1]) m_acc[i] = res;
        else if (acc_clr) m_acc[i] = 0;
        if (sb_on && i == 0) begin
          sb_q.push_back(res);
          sb_pushed++;
        end
      end else begin
        if (acc_clr) m_acc[i] = 0;
        if (out_ready) m_ov[i] = 0;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("out_valid[%0d]", i), d_ov[i], m_ov[i]);
      chk($sformatf("acc[%0d]", i), d_acc[i], m_acc[i]);
      if (m_ov[i] || rst) begin
        chk($sformatf("result[%0d]", i), d_res[i], m_res[i]);
        chk($sformatf("flags[%0d]", i), {d_c[i], d_o[i], d_z[i], d_n[i]},
            {m_c[i], m_o[i], m_z[i], m_n[i]});
      end
    end
  endtask

  task automatic op(input logic [1:0] md, input logic [7:0] av, input logic [7:0] bv,
                    input logic clr, input logic iv, input logic ordy);
    mode = md; a = av; b = bv; acc_clr = clr; in_valid = iv; out_ready = ordy;
    step();
  endtask

  initial begin
    vt[0] = '{0, 2'b00, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 1};
    vt[1] = '{0, 2'b01, 8'h05, 8'h05, 8'h00, 1, 0, 1, 0};
    vt[2] = '{0, 2'b01, 8'h00, 8'h01, 8'hFF, 0, 0, 0, 1};
    vt[3] = '{1, 2'b00, 8'h70, 8'h20, 8'h7F, 0, 1, 0, 0};
    vt[4] = '{1, 2'b01, 8'h80, 8'h01, 8'h80, 1, 1, 0, 1};
    vt[5] = '{0, 2'b00, 8'hFF, 8'h01, 8'h00, 1, 0, 1, 0};
    vt[6] = '{1, 2'b00, 8'h80, 8'h80, 8'h80, 1, 1, 0, 1};

    for (int i = 0; i < 2; i++) begin
      m_ov[i] = 0; m_res[i] = 0; m_c[i] = 0; m_o[i] = 0; m_z[i] = 0; m_n[i] = 0; m_acc[i] = 0;
    end

    // reset
    rst = 1; mode = 0; a = 0; b = 0; acc_clr = 0; in_valid = 0; out_ready = 1;
    step();
    step();
    chk("rst_out_valid", d_ov[0], 1'b0);
    chk("rst_result", d_res[1], 8'h00);
    chk("rst_acc", d_acc[0], 8'h00);
    rst = 0;

    // directed vectors
    foreach (vt[k]) begin
      op(vt[k].mode, vt[k].a, vt[k].b, 1'b0, 1'b1, 1'b1);
      chk($sformatf("vec%0d_result", k), d_res[vt[k].sat], vt[k].res);
      chk($sformatf("vec%0d_cozn", k), {d_c[vt[k].sat], d_o[vt[k].sat], d_z[vt[k].sat], d_n[vt[k].sat]},
          {vt[k].c, vt[k].o, vt[k].z, vt[k].n});
      chk($sformatf("vec%0d_valid", k), d_ov[vt[k].sat], 1'b1);
    end

    // accumulate sequence
    op(2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("acc_clear", d_acc[0], 8'h00);
    op(2'b10, 8'hEE, 8'd3, 1'b0, 1'b1, 1'b1);
    chk("acc_seq_3", d_res[0], 8'd3);
    op(2'b10, 8'hEE, 8'd4, 1'b0, 1'b1, 1'b1);
    chk("acc_seq_7", d_res[0], 8'd7);
    op(2'b10, 8'hEE, 8'd5, 1'b0, 1'b1, 1'b1);
    chk("acc_seq_12", d_res[1], 8'd12);
    op(2'b11, 8'hEE, 8'd2, 1'b0, 1'b1, 1'b1);
    chk("acc_seq_10", d_res[0], 8'd10);
    chk("acc_val_10", d_acc[1], 8'd10);
    op(2'b10, 8'hEE, 8'd9, 1'b1, 1'b1, 1'b1);
    chk("clr_acc_res_9", d_res[0], 8'd9);
    chk("clr_acc_acc_9", d_acc[0], 8'd9);

    // backpressure with scoreboard
    sb_on = 1'b1;
    sb_q.push_back(8'd9);
    for (int k = 0; k < 3; k++) begin
      op(2'b00, 8'h11, 8'h22, 1'b0, 1'b1, 1'b0);
      chk("bp_in_ready", d_rdy[0], 1'b0);
      chk("bp_result_held", d_res[0], 8'd9);
    end
    op(2'b00, 8'h11, 8'h22, 1'b0, 1'b1, 1'b1);
    chk("bp_first_release", d_res[0], 8'h33);
    for (int k = 1; k < 5; k++) op(2'b01, 8'(k * 16), 8'(k), 1'b0, 1'b1, 1'b1);
    op(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("sb_pushed", sb_pushed, 5);
    chk("sb_popped", sb_popped, 6);
    chk("sb_empty", sb_q.size(), 0);
    sb_on = 1'b0;

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
         ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
    end

    // reset while a result is pending
    op(2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    op(2'b10, 8'h00, 8'h2A, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_acc", d_acc[0], 8'h2A);
    chk("pre_rst_valid", d_ov[0], 1'b1);
    rst = 1;
    op(2'b10, 8'h00, 8'h05, 1'b0, 1'b1, 1'b0);
    chk("mid_rst_valid", d_ov[0], 1'b0);
    chk("mid_rst_acc", d_acc[0], 8'h00);
    chk("mid_rst_result", d_res[0], 8'h00);
    chk("mid_rst_in_ready", d_rdy[0], 1'b1);
    rst = 0;
    op(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("post_rst_in_ready", d_rdy[1], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addsub_acc_unit.md
ADDSUB_ACC_UNIT -- requirements
Module: addsub_acc_unit

Interface
Parameters
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and result width in bits; legal range 2..64.
REQ-002 The block SHALL have parameter SAT, default 0: 0 = wrap-around result; 1 = signed saturation on overflow.

Ports
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 mode  input  2  operation select: 00 A+B; 01 A-B; 10 ACC+B; 11 ACC-B.
REQ-008 A  input  WIDTH  first operand; ignored for modes 10/11.
REQ-009 B  input  WIDTH  second operand.
REQ-010 acc_clr  input  1  clear accumulator; sampled every cycle regardless of handshake.
REQ-011 out_valid  output  1  result register holds an unconsumed result.
REQ-012 out_ready  input  1  downstream accepts the result this cycle.
REQ-013 result  output  WIDTH  registered result.
REQ-014 carry  output  1  registered carry-out; for subtract, 1 = no borrow.
REQ-015 ovf  output  1  registered signed overflow, computed before saturation.
REQ-016 zero  output  1  registered flag, 1 when result == 0 after saturation.
REQ-017 neg  output  1  registered flag, MSB of result after saturation.
REQ-018 acc  output  WIDTH  current accumulator value.

Function
REQ-019 Accept SHALL occur in a cycle where in_valid && in_ready are both 1.
REQ-020 Ready rule SHALL be in_ready = !out_valid || out_ready, which allows back-to-back accepts at full throughput.
REQ-021 Latency SHALL be 1 cycle: an operation accepted at edge N appears on result and the flags with out_valid=1 after edge N.
REQ-022 Datapath SHALL be one adder computing X + (B xor {WIDTH{sub}}) + sub, where sub = mode[0], X = A for modes 00/01 and X = acc for modes 10/11.
REQ-023 carry SHALL be bit WIDTH of the (WIDTH+1)-bit sum.
REQ-024 ovf SHALL be 1 when X[MSB] == Beff[MSB] and sum[MSB] != X[MSB], where Beff = B xor {WIDTH{sub}}.
REQ-025 With SAT=1 and ovf=1, result SHALL be the signed max 0111..1 if X is non-negative, and the signed min 1000..0 otherwise.
REQ-026 With SAT=0, result SHALL be sum[WIDTH-1:0].
REQ-027 On accept of mode 10/11, acc SHALL load the final result value (post-saturation) at the same edge.
REQ-028 On accept of mode 00/01, acc SHALL be left unchanged.
REQ-029 acc_clr=1 without an accumulate accept SHALL set acc to 0 at the next edge.
REQ-030 acc_clr=1 with an accumulate accept in the same cycle SHALL use X = 0, so the result is 0±B, and acc SHALL load that result.
REQ-031 With out_valid=1 and out_ready=0, result and all flags SHALL hold stable.
REQ-032 out_valid SHALL be set on accept, cleared on (out_ready && !accept), and held otherwise.
REQ-033 in_valid=1 while in_ready=0 SHALL be ignored: no state change, and the upstream holds its request.

Reset
REQ-034 rst=1 at an edge SHALL set out_valid, result, carry, ovf, zero, neg and acc to 0.
REQ-035 rst SHALL take priority over accept and acc_clr.
REQ-036 A pending, unconsumed result SHALL be discarded by reset.
REQ-037 in_ready SHALL read 1 during and after reset.

Verification (WIDTH=8)
REQ-038 SAT=0, mode 00, A=0x7F, B=0x01 -> result 0x80, ovf=1, carry=0, neg=1, zero=0, one cycle after accept.
REQ-039 SAT=0, mode 01, A=0x05, B=0x05 -> result 0x00, carry=1, zero=1, ovf=0. Then A=0x00, B=0x01 -> result 0xFF, carry=0, neg=1.
REQ-040 SAT=1, mode 00, A=0x70, B=0x20 -> result 0x7F, ovf=1. Then mode 01, A=0x80, B=0x01 -> result 0x80, ovf=1.
REQ-041 Accumulate sequence: acc_clr, then mode 10 with B=3, 4, 5, then mode 11 with B=2 -> results 3, 7, 12, 10 and acc=10; an acc_clr together with mode 10, B=9 -> result 9, acc=9.
REQ-042 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and result held; releasing out_ready gives one accept per cycle with no loss or duplication, checked against a scoreboard.
REQ-043 Mid-operation reset: assert rst while out_valid=1 and acc=0x2A -> after the edge out_valid=0, acc=0, result=0, in_ready=1.
